// File: rtl/bet_entry_buf.sv
// -----------------------------------------------------------------------------
// bet_entry_buf
//
// Clocked bet-entry block. An operator first scans a line count, then scans
// NUMS distinct numbers for each line. Every completed line is copied into an
// internal buffer which the draw-compare logic reads back through a
// combinational random-access port.
//
// Optional feature (compile-time macro): BET_UNDO_EN
//   When defined, an 'undo' strobe during entry throws away the line in
//   progress. When not defined, the 'undo' port exists but is ignored.
//
// Parameters
//   W          bit width of a bet number and of N_in
//   NUMS       numbers per bet line (2..8)
//   MAX_LINES  maximum number of bet lines (1..15)
//   MAX_VAL    largest legal bet number (legal range 1..MAX_VAL)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   scan         one-cycle strobe: N_in is valid this cycle
//   SYSRDY       system ready; scans are accepted only when high
//   N_in         entered value (line count or bet number)
//   undo         one-cycle strobe: discard line in progress (BET_UNDO_EN)
//   rd_line      read-port line index
//   rd_pos       read-port position index
//   rd_data      buffer[rd_line][rd_pos], 0 if the line is not stored yet
//   cur_line     numbers of the line in progress, position 0 in the LSBs
//   RD_ERR       last accepted scan was rejected
//   V            a valid line count was just taken
//   finish       all lines have been entered
//   number       position the next number will fill
//   lines_total  line count entered
//   lines_done   complete lines stored
// -----------------------------------------------------------------------------
module bet_entry_buf #(
  parameter int W         = 5,
  parameter int NUMS      = 4,
  parameter int MAX_LINES = 6,
  parameter int MAX_VAL   = 31,
  localparam int LW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1,
  localparam int PW = (NUMS > 1) ? $clog2(NUMS) : 1,
  localparam int CW = $clog2(MAX_LINES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan,
  input  logic              SYSRDY,
  input  logic [W-1:0]      N_in,
  input  logic              undo,
  input  logic [LW-1:0]     rd_line,
  input  logic [PW-1:0]     rd_pos,
  output logic [W-1:0]      rd_data,
  output logic [NUMS*W-1:0] cur_line,
  output logic              RD_ERR,
  output logic              V,
  output logic              finish,
  output logic [PW-1:0]     number,
  output logic [CW-1:0]     lines_total,
  output logic [CW-1:0]     lines_done
);

  localparam logic [1:0] S_COUNT = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_buf [MAX_LINES][NUMS];
  logic [W-1:0]  r_cur [NUMS];
  logic          r_err;
  logic          r_v;
  logic          r_fin;
  logic [PW-1:0] r_num;
  logic [CW-1:0] r_total;
  logic [CW-1:0] r_done;

  logic          w_accept;
  logic          w_undo;
  logic          w_dup;
  logic          w_countOk;
  logic          w_numOk;
  logic          w_lineFull;
  logic [CW-1:0] w_doneNext;

  assign w_accept   = scan && SYSRDY;
  assign w_lineFull = (int'(r_num) == NUMS - 1);
  assign w_doneNext = r_done + 1'b1;

`ifdef BET_UNDO_EN
  // Undo only matters while a line is being entered; COUNT and DONE ignore it.
  assign w_undo = undo && (r_state == S_ENTRY);
`else
  logic w_unused;
  assign w_unused = undo;
  assign w_undo   = 1'b0;
`endif

  // A number is a duplicate if it matches any position already filled in the
  // current line; positions at or beyond 'number' are stale and not compared.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUMS; i++) begin
      if ((i < int'(r_num)) && (r_cur[i] == N_in)) begin
        w_dup = 1'b1;
      end
    end
  end

  assign w_countOk = (N_in != '0) && (int'(N_in) <= MAX_LINES);
  assign w_numOk   = (N_in != '0) && (int'(N_in) <= MAX_VAL) && !w_dup;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COUNT;
      r_err   <= 1'b0;
      r_v     <= 1'b0;
      r_fin   <= 1'b0;
      r_num   <= '0;
      r_total <= '0;
      r_done  <= '0;
      for (int p = 0; p < NUMS; p++) begin
        r_cur[p] <= '0;
      end
      for (int l = 0; l < MAX_LINES; l++) begin
        for (int p = 0; p < NUMS; p++) begin
          r_buf[l][p] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_accept) begin
            if (!w_countOk) begin
              r_err <= 1'b1;
            end else begin
              r_total <= CW'(N_in);
              r_done  <= '0;
              r_num   <= '0;
              r_v     <= 1'b1;
              r_err   <= 1'b0;
              for (int p = 0; p < NUMS; p++) begin
                r_cur[p] <= '0;
              end
              r_state <= S_ENTRY;
            end
          end
        end

        S_ENTRY: begin
          if (w_undo) begin
            // Undo wins over a simultaneous scan, which is simply dropped.
            r_num <= '0;
            r_err <= 1'b0;
            for (int p = 0; p < NUMS; p++) begin
              r_cur[p] <= '0;
            end
          end else if (w_accept) begin
            if (!w_numOk) begin
              r_err <= 1'b1;
            end else begin
              r_err <= 1'b0;
              r_v   <= 1'b0;
              if (!w_lineFull) begin
                r_cur[r_num] <= N_in;
                r_num        <= r_num + 1'b1;
              end else begin
                // Last number of the line: the stored copy takes N_in directly
                // since r_cur does not hold it yet.
                for (int p = 0; p < NUMS; p++) begin
                  r_buf[r_done][p] <= (p == NUMS - 1) ? N_in : r_cur[p];
                  r_cur[p]         <= '0;
                end
                r_done <= w_doneNext;
                r_num  <= '0;
                if (w_doneNext == r_total) begin
                  r_fin   <= 1'b1;
                  r_state <= S_DONE;
                end
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_COUNT;
        end
      endcase
    end
  end

  // Only completed lines are visible; anything at or beyond lines_done reads 0.
  always_comb begin
    rd_data = '0;
    if ((int'(rd_line) < int'(r_done)) && (int'(rd_pos) < NUMS)) begin
      rd_data = r_buf[rd_line][rd_pos];
    end
  end

  for (genvar g = 0; g < NUMS; g++) begin : g_curLine
    assign cur_line[g*W +: W] = r_cur[g];
  end

  assign RD_ERR      = r_err;
  assign V           = r_v;
  assign finish      = r_fin;
  assign number      = r_num;
  assign lines_total = r_total;
  assign lines_done  = r_done;

endmodule
